// File: rtl/rip_uart_tx.sv
// UART transmitter popping characters from a first-word-fall-through FIFO, LSB first, 1 stop bit.
// Define RIP_UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
//
// state  | meaning
// IDLE   | line high, waiting for en and a non-empty FIFO
// START  | start bit (tx low)
// DATA   | data bits, LSB first, shifted out of shift_reg
// PARITY | even parity over the data bits (RIP_UART_TX_PARITY_EN only)
// STOP   | stop bit; last cycle may pop the next character directly
module rip_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    input  logic                  fifo_r_empty,
    output logic                  fifo_r_en,
    output logic                  tx,
    output logic                  busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

`ifdef RIP_UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                  state, state_next;
    logic [BAUD_W-1:0]       baud_cnt, baud_next;
    logic [BIT_W-1:0]        bit_cnt, bit_next;
    logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
    logic                    tx_next;
    logic                    last_cycle;
    logic                    pop;
`ifdef RIP_UART_TX_PARITY_EN
    logic                    parity_q, parity_next;
`endif

    assign last_cycle = (baud_cnt == BAUD_LAST);
    assign pop = rst_n && en && !fifo_r_empty &&
                 ((state == S_IDLE) || ((state == S_STOP) && last_cycle));
    assign fifo_r_en = pop;

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt + 1'b1;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
`ifdef RIP_UART_TX_PARITY_EN
        parity_next = parity_q;
`endif
        case (state)
            S_IDLE: baud_next = '0;
            S_START: begin
                if (last_cycle) begin
                    state_next = S_DATA;
                    baud_next  = '0;
                    bit_next   = '0;
                end
            end
            S_DATA: begin
                if (last_cycle) begin
                    baud_next = '0;
                    if (bit_cnt == BIT_LAST) begin
`ifdef RIP_UART_TX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        bit_next   = bit_cnt + 1'b1;
                        shift_next = shift_reg >> 1;
                    end
                end
            end
`ifdef RIP_UART_TX_PARITY_EN
            S_PARITY: begin
                if (last_cycle) begin
                    state_next = S_STOP;
                    baud_next  = '0;
                end
            end
`endif
            S_STOP: begin
                if (last_cycle) begin
                    state_next = S_IDLE;
                    baud_next  = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
                baud_next  = '0;
            end
        endcase

        // A pop overrides the normal progression: it only happens in IDLE or at the end of STOP.
        if (pop) begin
            state_next = S_START;
            shift_next = fifo_r_data;
            baud_next  = '0;
            bit_next   = '0;
`ifdef RIP_UART_TX_PARITY_EN
            parity_next = ^fifo_r_data;
`endif
        end

        case (state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shift_next[0];
`ifdef RIP_UART_TX_PARITY_EN
            S_PARITY: tx_next = parity_next;
`endif
            default:  tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
`ifdef RIP_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_cnt   <= bit_next;
            shift_reg <= shift_next;
            tx        <= tx_next;
            busy      <= (state_next != S_IDLE);
`ifdef RIP_UART_TX_PARITY_EN
            parity_q  <= parity_next;
`endif
        end
    end

endmodule

// File: tb/tb_rip_uart_tx.sv
// Bench for rip_uart_tx: FIFO model plus a per-cycle expected-waveform queue built from frame rules.
// Honours RIP_UART_TX_PARITY_EN for the expected frame shape.
module tb_rip_uart_tx;

    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef RIP_UART_TX_PARITY_EN
    localparam int FRAME = (DW + 3) * CPB;
`else
    localparam int FRAME = (DW + 2) * CPB;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [DW-1:0] fifo_r_data;
    logic          fifo_r_empty;
    logic          fifo_r_en;
    logic          tx;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] fifo_q[$];
    logic          exp_q[$];
    logic          mon_on = 1'b0;
    int            busy_cnt = 0;
    int            pop_cnt = 0;
    int            model_pops = 0;
    int            pushes = 0;

    logic          e_tx, e_busy, e_pop;
    logic [DW-1:0] e_data;

    rip_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .fifo_r_data  (fifo_r_data),
        .fifo_r_empty (fifo_r_empty),
        .fifo_r_en    (fifo_r_en),
        .tx           (tx),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Garbage on the data bus while empty: the DUT must not sample it.
    task automatic refresh();
        fifo_r_empty = (fifo_q.size() == 0);
        fifo_r_data  = fifo_r_empty ? DW'($urandom) : fifo_q[0];
    endtask

    task automatic push(input logic [DW-1:0] v);
        fifo_q.push_back(v);
        pushes++;
        refresh();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        refresh();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reference: the expected line level for every future cycle, appended one frame per pop.
    always @(negedge clk) begin
        if (mon_on) begin
            e_busy = (exp_q.size() != 0);
            e_tx   = e_busy ? exp_q.pop_front() : 1'b1;
            e_pop  = rst_n && en && (fifo_q.size() != 0) && (exp_q.size() == 0);
            chk("tx", {31'd0, tx}, {31'd0, e_tx});
            chk("busy", {31'd0, busy}, {31'd0, e_busy});
            chk("fifo_r_en", {31'd0, fifo_r_en}, {31'd0, e_pop});
            if (fifo_r_en) chk("pop_when_empty", {31'd0, fifo_r_empty}, 32'd0);
            if (busy) busy_cnt++;
            if (fifo_r_en) pop_cnt++;
            if (!rst_n) begin
                exp_q.delete();
            end else if (e_pop) begin
                e_data = fifo_q.pop_front();
                model_pops++;
                for (int k = 0; k < CPB; k++) exp_q.push_back(1'b0);
                for (int b = 0; b < DW; b++)
                    for (int k = 0; k < CPB; k++) exp_q.push_back(e_data[b]);
`ifdef RIP_UART_TX_PARITY_EN
                for (int k = 0; k < CPB; k++) exp_q.push_back(^e_data);
`endif
                for (int k = 0; k < CPB; k++) exp_q.push_back(1'b1);
            end
        end
    end

    initial begin
        int p0, b0, guard;
        rst_n = 1'b0;
        en    = 1'b1;
        refresh();
        tick();
        mon_on = 1'b1;
        push(8'h99);
        tick();
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pop", {31'd0, fifo_r_en}, 32'd0);
        p0 = pop_cnt;
        rst_n = 1'b1;
        run(FRAME + 10);
        chk("post_rst_pops", pop_cnt - p0, 32'd1);

        // Single character
        p0 = pop_cnt; b0 = busy_cnt;
        push(8'hA5);
        run(FRAME + 10);
        chk("a5_pops", pop_cnt - p0, 32'd1);
        chk("a5_busy_cycles", busy_cnt - b0, FRAME);

        // Three back-to-back characters
        p0 = pop_cnt; b0 = busy_cnt;
        push(8'h00); push(8'hFF); push(8'h55);
        run(3 * FRAME + 10);
        chk("b2b_pops", pop_cnt - p0, 32'd3);
        chk("b2b_busy_cycles", busy_cnt - b0, 3 * FRAME);

        // Parity-pattern characters
        p0 = pop_cnt; b0 = busy_cnt;
        push(8'h07); push(8'h03);
        run(2 * FRAME + 10);
        chk("par_pops", pop_cnt - p0, 32'd2);
        chk("par_busy_cycles", busy_cnt - b0, 2 * FRAME);

        // Reset during data bit 3 of 0x3C, then 0x5A goes out whole
        p0 = pop_cnt;
        push(8'h3C); push(8'h5A);
        run(18);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        b0 = busy_cnt;
        run(FRAME + 10);
        chk("midrst_pops", pop_cnt - p0, 32'd2);
        chk("midrst_busy_cycles", busy_cnt - b0, FRAME);

        // en low blocks pops; lowered mid-frame it only blocks the next pop
        en = 1'b0;
        p0 = pop_cnt; b0 = busy_cnt;
        push(8'h11); push(8'h22);
        run(30);
        chk("en_low_pops", pop_cnt - p0, 32'd0);
        chk("en_low_busy", busy_cnt - b0, 32'd0);
        en = 1'b1;
        run(10);
        en = 1'b0;
        run(FRAME + 20);
        chk("en_mid_pops", pop_cnt - p0, 32'd1);
        chk("en_mid_busy_cycles", busy_cnt - b0, FRAME);

        // Random traffic
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 3) == 0 && fifo_q.size() < 6) push(DW'($urandom_range(0, 255)));
            if ($urandom_range(0, 59) == 0) en = ~en;
            rst_n = ($urandom_range(0, 1999) != 0);
            tick();
        end
        rst_n = 1'b1;
        en    = 1'b1;
        guard = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && guard < 20 * FRAME) begin
            tick();
            guard++;
        end
        if (guard >= 20 * FRAME) chk("drain_timeout", 32'd1, 32'd0);
        run(5);
        chk("drain_fifo_empty", fifo_q.size(), 32'd0);
        chk("pop_total", pop_cnt, model_pops);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_tx", {31'd0, tx}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rip_uart_tx.md
RIP_UART_TX -- requirements
Module: rip_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868 (100 MHz / 115200 baud), clock cycles per serial bit; SHALL be >= 2.
REQ-002 Parameter DATA_WIDTH, default 8, bits per character; SHALL be 5..8.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 en  input  1  transmit enable; when low, no new frame SHALL start.
REQ-006 fifo_r_data  input  DATA_WIDTH  head word of the upstream synchronous FIFO (first-word-fall-through).
REQ-007 fifo_r_empty  input  1  upstream FIFO empty flag.
REQ-008 fifo_r_en  output  1  pop strobe to the upstream FIFO, one cycle per character.
REQ-009 tx  output  1  serial line, idle high.
REQ-010 busy  output  1  high while a frame is in progress.

Function
REQ-011 States SHALL be IDLE, START, DATA, PARITY (only with the macro in REQ-030), STOP.
REQ-012 fifo_r_en SHALL be combinational: high exactly when (state==IDLE, or last cycle of STOP) and en==1 and fifo_r_empty==0 and rst_n==1.
REQ-013 In a cycle with fifo_r_en high, fifo_r_data SHALL be latched into the shift register, the baud counter cleared, and the state set to START.
REQ-014 The baud counter SHALL count 0..CLKS_PER_BIT-1; each non-IDLE state SHALL last exactly CLKS_PER_BIT cycles per bit.
REQ-015 tx SHALL be registered: 0 in START, shift-register bit 0 in DATA, parity bit in PARITY, 1 in STOP and IDLE.
REQ-016 Data SHALL be sent LSB first; the shift register SHALL shift right at each bit boundary in DATA.
REQ-017 A bit counter SHALL advance DATA to the next state after DATA_WIDTH bits.
REQ-018 STOP SHALL be one bit long; at its last cycle the FSM SHALL pop and enter START if REQ-012 holds, else enter IDLE.
REQ-019 Back-to-back characters SHALL produce no idle gap between the stop bit and the next start bit.
REQ-020 tx SHALL go low one cycle after the pop cycle (tx register latency one cycle).
REQ-021 busy SHALL be registered and high from the cycle tx first goes low until the cycle after the final stop bit when no next frame follows.
REQ-022 en deasserted mid-frame SHALL NOT abort the frame; it only blocks the next pop.
REQ-023 fifo_r_data SHALL be sampled only in pop cycles; changes at other times SHALL have no effect.
REQ-024 At most one pop SHALL occur per frame; fifo_r_en SHALL never be high when fifo_r_empty is high.

Reset
REQ-025 When rst_n is low at a rising edge: state IDLE, tx=1, busy=0, counters and shift register cleared.
REQ-026 fifo_r_en SHALL be 0 whenever rst_n is low.
REQ-027 Reset mid-frame SHALL abort the frame immediately, with tx=1 from the next cycle and no partial character resumed.
REQ-028 The first pop after reset release SHALL occur no earlier than the first cycle with rst_n high.

Configuration
REQ-029 Default, with the macro undefined: frame = 1 start + DATA_WIDTH data + 1 stop = (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
REQ-030 With RIP_UART_TX_PARITY_EN defined: a PARITY state between DATA and STOP SHALL send even parity (XOR of the data bits), and the frame SHALL be (DATA_WIDTH+3)*CLKS_PER_BIT cycles.

Verification (CLKS_PER_BIT=4, DATA_WIDTH=8)
REQ-031 Single char 0xA5, FIFO otherwise empty -> fifo_r_en high for 1 cycle; tx is 0, then 1,0,1,0,0,1,0,1, then 1, each for 4 cycles; busy is low 40 cycles after going high.
REQ-032 Three chars queued (0x00, 0xFF, 0x55) -> 3 pops 40 cycles apart; tx stop-to-start has no gap; total 120 busy cycles.
REQ-033 en low with FIFO non-empty -> no pop and tx stays 1; en raised mid-frame then lowered -> current frame completes, no further pop.
REQ-034 rst_n low for 1 cycle at bit 3 of 0x3C -> tx=1 and busy=0 next cycle; after release the next queued char is sent complete.
REQ-035 With RIP_UART_TX_PARITY_EN, chars 0x07 and 0x03 -> parity bits 1 and 0; frames are 44 cycles each.
REQ-036 Random stimulus with a scoreboard against the FIFO model -> all characters received in order, and no pop ever occurs while fifo_r_empty=1.
